// File: rtl/goose_jump_ctrl.sv
// goose_jump_ctrl: per-frame vertical physics for the goose sprite.
// Converts synchronized jump/duck buttons into a registered height, a pose
// state and a one-cycle landing pulse. Motion advances only on frame_tick;
// a jump press between ticks is latched so short taps are not lost.
//
// frame_tick is a single-cycle strobe with no handshake: every tick is
// consumed on the cycle it is high, and the pending-jump latch is always
// cleared on that cycle whether or not the jump was taken.
module goose_jump_ctrl #(
    parameter int Y_W      = 7,
    parameter int VEL_W    = 6,
    parameter int JUMP_VEL = 12,
    parameter int GRAVITY  = 1,
    parameter int CUT_VEL  = 4,
    parameter int MAX_FALL = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           frame_tick,
    input  logic           jump_btn,
    input  logic           duck_btn,
    input  logic           game_over,
    output logic [Y_W-1:0] goose_y,
    output logic [1:0]     state,
    output logic           airborne,
    output logic           ducking,
    output logic           land_pulse
);

    typedef enum logic [1:0] {
        ST_GROUNDED = 2'd0,
        ST_AIR      = 2'd1,
        ST_DUCK     = 2'd2,
        ST_DEAD     = 2'd3
    } state_t;

    // Signed constants sized for the arithmetic they take part in.
    localparam logic signed [VEL_W-1:0] JUMP_V   = VEL_W'(JUMP_VEL);
    localparam logic signed [VEL_W-1:0] CUT_V    = VEL_W'(CUT_VEL);
    localparam logic signed [VEL_W:0]   GRAV_V   = (VEL_W+1)'(GRAVITY);
    localparam logic signed [VEL_W:0]   FALL_MIN = (VEL_W+1)'(-MAX_FALL);
    localparam logic signed [Y_W+1:0]   Y_MAX    = (Y_W+2)'((1 << Y_W) - 1);

    state_t                  state_q, state_n;
    logic [Y_W-1:0]          y_q, y_n;
    logic signed [VEL_W-1:0] vel_q, vel_n;
    logic                    jump_btn_d;
    logic                    jump_pending, pending_n;
    logic                    land_q, land_n;
    logic                    airborne_q, ducking_q;

    logic                    jump_rise;
    logic                    jump_now;
    logic signed [VEL_W-1:0] vb;
    logic signed [Y_W+1:0]   yn;
    logic signed [VEL_W:0]   vel_dec;
    logic signed [VEL_W-1:0] vel_fall;

    assign goose_y    = y_q;
    assign state      = state_q;
    assign airborne   = airborne_q;
    assign ducking    = ducking_q;
    assign land_pulse = land_q;

    // An edge coinciding with a tick is honoured on that very tick.
    assign jump_rise = jump_btn & ~jump_btn_d;
    assign jump_now  = jump_pending | jump_rise;
    assign pending_n = frame_tick ? 1'b0 : jump_now;

    // Airborne motion terms: an early release caps upward speed, then
    // gravity applies with a terminal fall speed.
    always_comb begin
        vb = vel_q;
        if (!jump_btn && (vel_q > CUT_V)) begin
            vb = CUT_V;
        end
        yn      = signed'({2'b00, y_q}) + (Y_W+2)'(vb);
        vel_dec = (VEL_W+1)'(vb) - GRAV_V;
        if (vel_dec < FALL_MIN) begin
            vel_fall = FALL_MIN[VEL_W-1:0];
        end else begin
            vel_fall = vel_dec[VEL_W-1:0];
        end
    end

    // Next-state and datapath update; game_over overrides everything.
    always_comb begin
        state_n = state_q;
        y_n     = y_q;
        vel_n   = vel_q;
        land_n  = 1'b0;
        if (game_over) begin
            state_n = ST_DEAD;
            vel_n   = '0;
        end else if (frame_tick) begin
            case (state_q)
                ST_GROUNDED: begin
                    if (jump_now) begin
                        state_n = ST_AIR;
                        vel_n   = JUMP_V;
                    end else if (duck_btn) begin
                        state_n = ST_DUCK;
                    end
                end
                ST_DUCK: begin
                    if (jump_now) begin
                        state_n = ST_AIR;
                        vel_n   = JUMP_V;
                    end else if (!duck_btn) begin
                        state_n = ST_GROUNDED;
                    end
                end
                ST_AIR: begin
                    vel_n = vel_fall;
                    if (yn <= 0) begin
                        y_n     = '0;
                        vel_n   = '0;
                        state_n = ST_GROUNDED;
                        land_n  = 1'b1;
                    end else if (yn > Y_MAX) begin
                        y_n   = Y_MAX[Y_W-1:0];
                        vel_n = '0;
                    end else begin
                        y_n = yn[Y_W-1:0];
                    end
                end
                ST_DEAD: begin
                    state_n = ST_GROUNDED;
                    y_n     = '0;
                    vel_n   = '0;
                end
                default: begin
                    state_n = ST_GROUNDED;
                end
            endcase
        end
    end

    // State, datapath and registered pose flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_GROUNDED;
            y_q          <= '0;
            vel_q        <= '0;
            jump_btn_d   <= 1'b0;
            jump_pending <= 1'b0;
            land_q       <= 1'b0;
            airborne_q   <= 1'b0;
            ducking_q    <= 1'b0;
        end else begin
            state_q      <= state_n;
            y_q          <= y_n;
            vel_q        <= vel_n;
            jump_btn_d   <= jump_btn;
            jump_pending <= pending_n;
            land_q       <= land_n;
            airborne_q   <= (state_n == ST_AIR);
            ducking_q    <= (state_n == ST_DUCK);
        end
    end

endmodule
